// File: rtl/ripple_count_sampler_if.sv
// Bus between the ripple-counter sampler and its neighbours: the raw counter
// bus and request going in, the capture status and results coming out.
interface ripple_count_sampler_if #(
    parameter int SIZE = 4
);
    logic [SIZE-1:0] cnt_in;
    logic            up;
    logic            sample_req;
    logic            busy;
    logic            valid_out;
    logic            err;
    logic [SIZE-1:0] count_out;
    logic [SIZE-1:0] delta_out;
    logic            wrap;

    modport master (
        output cnt_in, up, sample_req,
        input  busy, valid_out, err, count_out, delta_out, wrap
    );

    modport slave (
        input  cnt_in, up, sample_req,
        output busy, valid_out, err, count_out, delta_out, wrap
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Synchronizes an asynchronous ripple counter bus into clk, waits for it to hold
// stable, then reports the count, the modular distance travelled and a wrap flag.
module ripple_count_sampler #(
    parameter int SIZE          = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_TRIES     = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    ripple_count_sampler_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] s1_q, s2_q, s3_q;
    logic [SW-1:0]   stable_q, stable_d;
    logic [TW-1:0]   try_q, try_d;
    logic [SIZE-1:0] prev_q, prev_d;
    logic [SIZE-1:0] count_q, count_d;
    logic [SIZE-1:0] delta_q, delta_d;
    logic            wrap_q, wrap_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            stable_q <= '0;
            try_q    <= '0;
            prev_q   <= '0;
            count_q  <= '0;
            delta_q  <= '0;
            wrap_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= bus.cnt_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            stable_q <= stable_d;
            try_q    <= try_d;
            prev_q   <= prev_d;
            count_q  <= count_d;
            delta_q  <= delta_d;
            wrap_q   <= wrap_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        try_d    = try_q;
        prev_d   = prev_q;
        count_d  = count_q;
        delta_d  = delta_q;
        wrap_d   = wrap_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sample_req) begin
                    state_d  = SETTLE;
                    stable_d = '0;
                    try_d    = '0;
                end
            end
            SETTLE: begin
                if (s2_q == s3_q) begin
                    stable_d = stable_q + SW'(1);
                end else begin
                    stable_d = '0;
                    try_d    = try_q + TW'(1);
                end

                // Accept is tested first so it wins over a simultaneous abort.
                if (stable_d == SW'(STABLE_CYCLES)) begin
                    state_d = IDLE;
                    count_d = s2_q;
                    prev_d  = s2_q;
                    valid_d = 1'b1;
                    if (bus.up) begin
                        delta_d = s2_q - prev_q;
                        wrap_d  = (s2_q < prev_q);
                    end else begin
                        delta_d = prev_q - s2_q;
                        wrap_d  = (s2_q > prev_q);
                    end
                end else if (try_d == TW'(MAX_TRIES)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q == SETTLE);
    assign bus.valid_out = valid_q;
    assign bus.err       = err_q;
    assign bus.count_out = count_q;
    assign bus.delta_out = delta_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler: a table of static captures followed by
// the abort, back-to-back request and mid-request reset sequences.
module tb_ripple_count_sampler;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ripple_count_sampler_if #(.SIZE(4)) bus ();

    ripple_count_sampler #(
        .SIZE(4),
        .STABLE_CYCLES(2),
        .MAX_TRIES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [3:0] cnt;
        logic       up;
        logic [3:0] expCount;
        logic [3:0] expDelta;
        logic       expWrap;
    } vec_t;

    vec_t vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_valid"}, int'(bus.valid_out), 0);
        checkOutput({tag, "_err"}, int'(bus.err), 0);
        checkOutput({tag, "_count"}, int'(bus.count_out), 0);
        checkOutput({tag, "_delta"}, int'(bus.delta_out), 0);
        checkOutput({tag, "_wrap"}, int'(bus.wrap), 0);
    endtask

    // Present a static value and let it reach both s2 and s3.
    task automatic applyStimulus(input logic [3:0] cnt, input logic up);
        @(negedge clk);
        bus.cnt_in = cnt;
        bus.up     = up;
        repeat (4) @(posedge clk);
    endtask

    // Edges from the request edge to valid_out; -1 if it never came.
    task automatic runRequest(output int edges);
        @(negedge clk);
        bus.sample_req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_on_req", int'(bus.busy), 1);
        bus.sample_req = 1'b0;
        edges = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic checkPulseEnds(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_low"}, int'(bus.valid_out), 0);
        checkOutput({tag, "_busy_low"}, int'(bus.busy), 0);
    endtask

    initial begin
        int lat;
        int validCount;
        int firstAt;
        int secondAt;
        int abortAt;
        logic errSeen;
        logic [3:0] cntSeen, deltaSeen;
        logic wrapSeen;

        checks   = 0;
        failures = 0;

        vecs[0] = '{4'd5,  1'b1, 4'd5,  4'd5,  1'b0};
        vecs[1] = '{4'd14, 1'b1, 4'd14, 4'd9,  1'b0};
        vecs[2] = '{4'd2,  1'b1, 4'd2,  4'd4,  1'b1};
        vecs[3] = '{4'd3,  1'b1, 4'd3,  4'd1,  1'b0};
        vecs[4] = '{4'd13, 1'b0, 4'd13, 4'd6,  1'b1};
        vecs[5] = '{4'd13, 1'b0, 4'd13, 4'd0,  1'b0};
        vecs[6] = '{4'd10, 1'b0, 4'd10, 4'd3,  1'b0};
        vecs[7] = '{4'd10, 1'b1, 4'd10, 4'd0,  1'b0};
        vecs[8] = '{4'd0,  1'b0, 4'd0,  4'd10, 1'b0};
        vecs[9] = '{4'd15, 1'b0, 4'd15, 4'd1,  1'b1};

        rst_n          = 1'b0;
        bus.cnt_in     = 4'd0;
        bus.up         = 1'b1;
        bus.sample_req = 1'b0;
        #23;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].cnt, vecs[v].up);
            runRequest(lat);
            checkOutput($sformatf("vec%0d_latency", v), lat, 2);
            checkOutput($sformatf("vec%0d_count", v), int'(bus.count_out), int'(vecs[v].expCount));
            checkOutput($sformatf("vec%0d_delta", v), int'(bus.delta_out), int'(vecs[v].expDelta));
            checkOutput($sformatf("vec%0d_wrap", v), int'(bus.wrap), int'(vecs[v].expWrap));
            checkOutput($sformatf("vec%0d_err", v), int'(bus.err), 0);
            checkPulseEnds($sformatf("vec%0d", v));
        end

        // Never-stable input: bit0 toggles each cycle, request issued on iteration 6.
        validCount = 0;
        abortAt    = -1;
        errSeen    = 1'b0;
        cntSeen    = 4'd0;
        deltaSeen  = 4'd0;
        wrapSeen   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.cnt_in[0]  = ~bus.cnt_in[0];
            bus.sample_req = (i == 6);
            @(posedge clk);
            #1;
            if (bus.valid_out) begin
                validCount++;
                abortAt   = i - 6;
                errSeen   = bus.err;
                cntSeen   = bus.count_out;
                deltaSeen = bus.delta_out;
                wrapSeen  = bus.wrap;
            end
        end
        checkOutput("abort_pulses", validCount, 1);
        checkOutput("abort_latency", abortAt, 8);
        checkOutput("abort_err", int'(errSeen), 1);
        checkOutput("abort_count_kept", int'(cntSeen), 15);
        checkOutput("abort_delta_kept", int'(deltaSeen), 1);
        checkOutput("abort_wrap_kept", int'(wrapSeen), 1);
        checkOutput("abort_err_cleared", int'(bus.err), 0);

        applyStimulus(4'd7, 1'b1);
        runRequest(lat);
        checkOutput("post_abort_latency", lat, 2);
        checkOutput("post_abort_count", int'(bus.count_out), 7);
        checkOutput("post_abort_delta", int'(bus.delta_out), 8);
        checkOutput("post_abort_wrap", int'(bus.wrap), 1);
        checkOutput("post_abort_err", int'(bus.err), 0);
        checkPulseEnds("post_abort");

        // Request held high across edges 0..4: captures complete at edges 2 and 5.
        applyStimulus(4'd9, 1'b1);
        @(negedge clk);
        bus.sample_req = 1'b1;
        validCount = 0;
        firstAt    = -1;
        secondAt   = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) bus.sample_req = 1'b0;
            if (k == 2) checkOutput("b2b_idle_after_accept", int'(bus.busy), 0);
            if (k == 3) checkOutput("b2b_rearm", int'(bus.busy), 1);
            if (bus.valid_out) begin
                validCount++;
                if (validCount == 1) firstAt = k;
                else if (validCount == 2) secondAt = k;
            end
        end
        checkOutput("b2b_pulses", validCount, 2);
        checkOutput("b2b_first_at", firstAt, 2);
        checkOutput("b2b_second_at", secondAt, 5);
        checkOutput("b2b_count", int'(bus.count_out), 9);
        checkOutput("b2b_delta", int'(bus.delta_out), 0);
        checkOutput("b2b_wrap", int'(bus.wrap), 0);

        // Reset while settling: everything clears at once and no result appears.
        applyStimulus(4'd4, 1'b1);
        @(negedge clk);
        bus.sample_req = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset_busy_before", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        validCount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.valid_out) validCount++;
        end
        checkOutput("midreset_no_pulse", validCount, 0);
        runRequest(lat);
        checkOutput("after_reset_latency", lat, 2);
        checkOutput("after_reset_count", int'(bus.count_out), 4);
        checkOutput("after_reset_delta", int'(bus.delta_out), 4);
        checkOutput("after_reset_wrap", int'(bus.wrap), 0);
        checkPulseEnds("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Clock-domain consumer for the asynchronous JK ripple up/down counter. Samples the counter's free-running `q` bus, which is skewed and glitchy during ripple, into the `clk` domain and accepts a value only after it has held stable. It then reports the captured count, the modular distance travelled since the previous capture, and a wrap-around flag. It sits directly downstream of the ripple counter and feeds software-visible status logic.

## Interface
- `SIZE`, default 4: counter width; must match the upstream ripple counter.
- `STABLE_CYCLES`, default 2, legal ≥1: consecutive matching synchronized samples required before capture.
- `MAX_TRIES`, default 8, legal ≥1: mismatching samples tolerated per request before abort.
- `clk`, input, 1: sampling clock.
- `rst_n`, input, 1: reset, asynchronous, active-low; clock `clk`.
- `cnt_in`, input, SIZE: ripple counter `q` bus; asynchronous to `clk`.
- `up`, input, 1: counter direction (1 = up); synchronous to `clk`, quasi-static.
- `sample_req`, input, 1: one-cycle request for a capture.
- `busy`, output, 1: high while a request is in progress.
- `valid_out`, output, 1: one-cycle pulse when a request completes.
- `err`, output, 1: qualifies `valid_out`; 1 = aborted, never stable.
- `count_out`, output, SIZE: last accepted count.
- `delta_out`, output, SIZE: modular distance between the last two accepted counts.
- `wrap`, output, 1: the last accepted capture crossed the terminal count.

## Operation
- **Synchronizer:** two-flop per-bit synchronizer `cnt_in` → `s1` → `s2`, plus a history register `s3` <= `s2`. All three reset to 0. The synchronizer runs continuously, independent of state.
- **FSM, IDLE:**
  - `busy`=0.
  - `sample_req`=1 → go to SETTLE. Clear `stable_cnt` and `try_cnt`. Set `busy`=1.
- **FSM, SETTLE:** evaluated each edge.
  - If `s2`==`s3`: `stable_cnt`++. Otherwise `stable_cnt`=0 and `try_cnt`++.
  - **Accept:** when `stable_cnt` reaches `STABLE_CYCLES`, do all of the following at that edge, then go to IDLE:
    - `count_out`<=`s2`, `prev`<=`s2`.
    - Compute delta and wrap (below).
    - `valid_out`<=1, `err`<=0.
  - **Abort:** when `try_cnt` reaches `MAX_TRIES`, at that edge set `valid_out`<=1 and `err`<=1, then go to IDLE.
    - `count_out`, `delta_out`, `wrap` and `prev` are unchanged.
  - If accept and abort occur on the same edge, accept wins.
- **Arithmetic:** all results are modulo 2^SIZE, unsigned, SIZE bits wide.
  - `up`=1: `delta`=`s2`-`prev`; `wrap`=(`s2`<`prev`).
  - `up`=0: `delta`=`prev`-`s2`; `wrap`=(`s2`>`prev`).
  - `up` is sampled on the accept edge only.
  - Equal values give `delta`=0 and `wrap`=0.
  - `prev` resets to 0, so the first capture measures from 0.
- **Request rules:**
  - `sample_req` while `busy`=1 is ignored. It is not queued.
  - `sample_req` on the same edge IDLE is re-entered is also ignored. The FSM must observe IDLE for at least one edge first.
- **Counter sizes:** `stable_cnt` and `try_cnt` are wide enough to hold `STABLE_CYCLES` and `MAX_TRIES` without overflow.

## Timing
- **Reset values:** `busy`, `valid_out`, `err`, `count_out`, `delta_out`, `wrap` = 0. State is IDLE. `prev`, `s1`, `s2`, `s3` = 0.
- **Reset mid-SETTLE:** all of the above apply immediately (asynchronously). No `valid_out` is produced for the interrupted request.
- **`valid_out`:** registered, high for exactly one cycle per accepted request.
- **`count_out`, `delta_out`, `wrap`:** registered; hold their values until the next accept.
- **`err`:** meaningful only when `valid_out`=1; it is 0 otherwise.
- **Input-to-`s2` latency:** a `cnt_in` change reaches `s2` two edges later.
- **Minimum request latency:** `sample_req` is seen at edge E0, so `busy` is high from E0. With a static input, `valid_out` is high in the cycle after edge E0+`STABLE_CYCLES`, and `busy` falls on that same edge.
- **Worst-case request latency:** E0+`MAX_TRIES`+`STABLE_CYCLES`-1 edges.
- **Input changes:** a `cnt_in` change that is still ripple-settling during SETTLE restarts the stability window. It never produces a partial or torn capture.

## Test plan
- **Static value, first capture:** `cnt_in`=5, `up`=1, reset then `sample_req` pulse.
  - `valid_out` pulses once, 2 edges after the request edge.
  - `count_out`=5, `delta_out`=5, `wrap`=0, `err`=0.
- **Up wrap:** accept 14, then change `cnt_in` to 2 with `up`=1 and request again.
  - `count_out`=2, `delta_out`=4, `wrap`=1.
- **Down wrap:** accept 3, then change `cnt_in` to 13 with `up`=0 and request again.
  - `count_out`=13, `delta_out`=6, `wrap`=1.
- **Never stable:** toggle `cnt_in` bit0 every cycle, then request with `MAX_TRIES`=8.
  - `valid_out` and `err` both 1 after 8 mismatches.
  - `count_out`, `delta_out`, `wrap` keep their prior values.
  - A following request with a static input succeeds normally.
- **Back-to-back requests:** hold `sample_req` high for 5 cycles.
  - Exactly one `valid_out` per accept.
  - Requests during `busy`=1 are ignored.
  - Requests resume only after IDLE has been observed for one edge.
- **Reset mid-operation:** assert `rst_n`=0 while in SETTLE.
  - All outputs go to 0 immediately.
  - No `valid_out` pulse appears after release.
  - The first request after release measures `delta` from 0.
